// File: rtl/led_seq_pkg.sv
// led_seq_pkg: register offsets, CTRL bit positions and FSM states for the LED pattern sequencer
package led_seq_pkg;
    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STAT   = 6'h04;
    localparam logic [5:0] A_PERIOD = 6'h08;
    localparam logic [5:0] A_LENGTH = 6'h0C;
    localparam logic [5:0] A_PAT    = 6'h10;
    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_LOOP  = 2;
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;
endpackage

// File: rtl/led_seq_if.sv
// led_seq_if: CPU config bus (rd_en_i/wr_en_i/addr_i/data_i in, data_o combinational read data out)
interface led_seq_if;
    logic        rd_en_i;
    logic        wr_en_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    modport master (output rd_en_i, wr_en_i, addr_i, data_i, input data_o);
    modport slave  (input rd_en_i, wr_en_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/led_seq_timer.sv
// led_seq_timer: loadable down-counter (clk, rst_n, load/val reload, en decrement, expire when count is 1)
module led_seq_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] val,
    output logic         expire
);
    logic [W-1:0] cnt;
    assign expire = cnt == W'(1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= load ? val : en ? cnt - W'(1) : cnt;
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: plays a CPU-loaded pattern table onto the LED data register
// ports: clk, rst_n, bus (config slave), led_wr_en_o/led_addr_o/led_data_o (LED write master), busy_o, done_o
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter int          PERIOD_W = 24,
    parameter logic [31:0] LED_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    led_seq_if.slave    bus,
    output logic        led_wr_en_o,
    output logic [31:0] led_addr_o,
    output logic [31:0] led_data_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int IW = $clog2(DEPTH);
    state_t state, state_n;
    logic loop, done_n, ctrl_wr, start, stop, last, decide, expire, pat_hit, unused;
    logic [PERIOD_W-1:0] period;
    logic [3:0] length, idx, idx_n, pi;
    logic [4:0] steps;
    logic [5:0] a;
    logic [7:0] pat [DEPTH];
    logic [7:0] hold;
    assign a = bus.addr_i[5:0];
    assign pi = a[5:2] - 4'd4;
    assign pat_hit = a[1:0] == 2'b0 && a >= A_PAT && {1'b0, pi} < 5'(DEPTH);
    assign ctrl_wr = bus.wr_en_i && a == A_CTRL;
    assign start = ctrl_wr && bus.data_i[B_START];
    assign stop = ctrl_wr && bus.data_i[B_STOP];
    assign unused = ^{bus.addr_i, bus.data_i};
    assign steps = length == 4'd0 ? 5'd1 : {1'b0, length} > 5'(DEPTH) ? 5'(DEPTH) : {1'b0, length};
    assign last = {1'b0, idx} >= steps - 5'd1;
    assign decide = (state == S_WRITE && period == '0) || (state == S_WAIT && expire);
    assign busy_o = state != S_IDLE;
    assign led_wr_en_o = state == S_WRITE;
    assign led_addr_o = LED_ADDR;
    // pattern is read live during the strobe so a table write lands on the next step
    assign led_data_o = {24'b0, led_wr_en_o ? pat[idx[IW-1:0]] : hold};
    assign bus.data_o = !bus.rd_en_i ? 32'b0 :
                        a == A_CTRL   ? {29'b0, loop, 2'b0} :
                        a == A_STAT   ? {20'b0, idx, 6'b0, done_o, busy_o} :
                        a == A_PERIOD ? 32'(period) :
                        a == A_LENGTH ? {28'b0, length} :
                        pat_hit       ? {24'b0, pat[pi[IW-1:0]]} : 32'b0;
    led_seq_timer #(.W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == S_WRITE),
        .en     (state == S_WAIT),
        .val    (period),
        .expire (expire)
    );
    always_comb begin
        state_n = state;
        idx_n = idx;
        done_n = done_o;
        if (stop) state_n = S_IDLE;
        else if (start) begin
            state_n = S_WRITE;
            idx_n = 4'd0;
            done_n = 1'b0;
        end else if (decide) begin
            state_n = !last || loop ? S_WRITE : S_IDLE;
            idx_n = !last ? idx + 4'd1 : loop ? 4'd0 : idx;
            done_n = last && !loop;
        end else if (state == S_WRITE) state_n = S_WAIT;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            idx <= '0;
            done_o <= 1'b0;
            hold <= '0;
            loop <= 1'b0;
            period <= '0;
            length <= '0;
            for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            done_o <= done_n;
            if (led_wr_en_o) hold <= pat[idx[IW-1:0]];
            if (ctrl_wr) loop <= bus.data_i[B_LOOP];
            if (bus.wr_en_i && a == A_PERIOD) period <= bus.data_i[PERIOD_W-1:0];
            if (bus.wr_en_i && a == A_LENGTH) length <= bus.data_i[3:0];
            if (bus.wr_en_i && pat_hit) pat[pi[IW-1:0]] <= bus.data_i[7:0];
        end
endmodule
